// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width and the state encoding used by both
// the controller and the responder side of the bridge.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SCK_HIGH = 3'd2,
    SCK_LOW  = 3'd3,
    TAIL     = 3'd4,
    HOLD     = 3'd5,
    GAP      = 3'd6
  } spi_state_e;

endpackage

// File: rtl/spi_controller.sv
// SPI mode-0 initiator, MSB first. Bytes arrive on a valid/ready stream,
// tx_last closes the chip-select frame, received bytes leave as a 1-cycle pulse.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              spi_sck,
  output logic              spi_csn,
  output logic              spi_sdo,
  input  logic              spi_sdi
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_controller: CLK_DIV must be 2 or more");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("spi_controller: GAP_CYCLES must be 1 or more");
    end
  endgenerate

  spi_state_e        state;
  logic [DW-1:0]     div_cnt;
  logic [2:0]        bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [BYTE_W-1:0] tx_shift;
  logic [BYTE_W-1:0] rx_shift;
  logic              last_q;

  logic          div_end;
  logic [DW-1:0] div_next;
  logic          accept;

  assign tx_ready = (state == IDLE) || (state == HOLD);
  assign accept   = tx_valid && tx_ready;
  assign div_end  = (div_cnt == DIV_MAX);
  assign div_next = div_end ? '0 : div_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      last_q   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_sck  <= 1'b0;
      spi_csn  <= 1'b1;
      spi_sdo  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      div_cnt  <= '0;
      case (state)
        IDLE, HOLD: begin
          // bit 7 goes out now; tx_shift keeps the remaining bits MSB-aligned
          if (accept) begin
            tx_shift <= {tx_data[BYTE_W-2:0], 1'b0};
            last_q   <= tx_last;
            bit_cnt  <= 3'd7;
            spi_sdo  <= tx_data[BYTE_W-1];
            spi_csn  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          div_cnt <= div_next;
          if (div_end) begin
            spi_sck <= 1'b1;
            state   <= SCK_HIGH;
          end
        end
        SCK_HIGH: begin
          div_cnt <= div_next;
          if (div_end) begin
            // sampling at the end of the high phase gives the responder
            // almost two half-periods after the falling edge to settle
            rx_shift <= {rx_shift[BYTE_W-2:0], spi_sdi};
            spi_sck  <= 1'b0;
            if (bit_cnt != 3'd0) begin
              spi_sdo  <= tx_shift[BYTE_W-1];
              tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
              state    <= SCK_LOW;
            end else begin
              rx_data  <= {rx_shift[BYTE_W-2:0], spi_sdi};
              rx_valid <= 1'b1;
              state    <= TAIL;
            end
          end
        end
        SCK_LOW: begin
          div_cnt <= div_next;
          if (div_end) begin
            spi_sck <= 1'b1;
            bit_cnt <= bit_cnt - 3'd1;
            state   <= SCK_HIGH;
          end
        end
        TAIL: begin
          div_cnt <= div_next;
          if (div_end) begin
            if (last_q) begin
              spi_csn <= 1'b1;
              spi_sdo <= 1'b0;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= HOLD;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_MAX) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: loopback, multi-byte frames, hold,
// tied sdi, mid-byte reset and delayed responders at CLK_DIV 2 and 7.
module tb_spi_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- main DUT, CLK_DIV=4 ----------------
  logic [7:0] tx_data, rx_data;
  logic tx_last, tx_valid, tx_ready, rx_valid;
  logic spi_sck, spi_csn, spi_sdo, spi_sdi;
  int   sdi_mode;  // 0 loopback, 1 tied high, 2 tied low

  assign spi_sdi = (sdi_mode == 0) ? spi_sdo : (sdi_mode == 1);

  spi_controller #(.CLK_DIV(4), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi)
  );

  logic       clr = 1'b0;
  logic       sck_q, csn_q;
  int         rises, sdo_hi, csn_low, csn_rise, gap_n, rx_n;
  logic [7:0] rx_log [8];

  always @(negedge clk) begin
    sck_q <= spi_sck;
    csn_q <= spi_csn;
    if (clr) begin
      rises <= 0; sdo_hi <= 0; csn_low <= 0; csn_rise <= 0; gap_n <= 0; rx_n <= 0;
    end else begin
      if (spi_sck && !sck_q) begin
        rises <= rises + 1;
        if (spi_sdo) sdo_hi <= sdo_hi + 1;
      end
      if (!spi_csn) csn_low <= csn_low + 1;
      if (spi_csn && !csn_q) csn_rise <= csn_rise + 1;
      if (spi_csn && !tx_ready) gap_n <= gap_n + 1;
      if (rx_valid) begin
        if (rx_n < 8) rx_log[rx_n] <= rx_data;
        rx_n <= rx_n + 1;
      end
    end
  end

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    chk("send_ready", tx_ready, 1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_n < n && k < 3000) begin @(negedge clk); k++; end
    chk("rx_wait", rx_n >= n, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(tx_ready && spi_csn) && k < 3000) begin @(negedge clk); k++; end
    chk("idle_wait", tx_ready && spi_csn, 1);
    @(negedge clk);
  endtask

  // ---------------- delayed responders, CLK_DIV=2 and 7 ----------------
  logic [7:0] c2_rx, c7_rx, r2_sr, r7_sr, d2_rx, d7_rx;
  logic c2_valid, c7_valid, c2_ready, c7_ready, c2_rxv, c7_rxv;
  logic c2_sck, c2_csn, c2_sdo, c7_sck, c7_csn, c7_sdo;
  logic r2_sck_q, r7_sck_q;
  int   r2_cnt, r7_cnt, d2_n, d7_n;

  spi_controller #(.CLK_DIV(2), .GAP_CYCLES(4)) dut_d2 (
    .clk(clk), .rst(rst),
    .tx_data(8'h00), .tx_last(1'b1), .tx_valid(c2_valid), .tx_ready(c2_ready),
    .rx_data(c2_rx), .rx_valid(c2_rxv),
    .spi_sck(c2_sck), .spi_csn(c2_csn), .spi_sdo(c2_sdo), .spi_sdi(r2_sr[7])
  );

  spi_controller #(.CLK_DIV(7), .GAP_CYCLES(4)) dut_d7 (
    .clk(clk), .rst(rst),
    .tx_data(8'h00), .tx_last(1'b1), .tx_valid(c7_valid), .tx_ready(c7_ready),
    .rx_data(c7_rx), .rx_valid(c7_rxv),
    .spi_sck(c7_sck), .spi_csn(c7_csn), .spi_sdo(c7_sdo), .spi_sdi(r7_sr[7])
  );

  // Responder: bit 7 ready at csn fall, each later bit changes 2*CLK_DIV-2
  // clocks (plus half a clock) after the sck falling edge.
  always @(negedge clk) begin
    r2_sck_q <= c2_sck;
    if (c2_csn) begin
      r2_sr <= 8'h96; r2_cnt <= 0;
    end else begin
      if (r2_cnt == 2*2-2) begin r2_sr <= r2_sr << 1; r2_cnt <= 0; end
      else if (r2_cnt > 0) r2_cnt <= r2_cnt + 1;
      if (r2_sck_q && !c2_sck) r2_cnt <= 1;
    end
    if (c2_rxv) begin d2_rx <= c2_rx; d2_n <= d2_n + 1; end
  end

  always @(negedge clk) begin
    r7_sck_q <= c7_sck;
    if (c7_csn) begin
      r7_sr <= 8'h96; r7_cnt <= 0;
    end else begin
      if (r7_cnt == 2*7-2) begin r7_sr <= r7_sr << 1; r7_cnt <= 0; end
      else if (r7_cnt > 0) r7_cnt <= r7_cnt + 1;
      if (r7_sck_q && !c7_sck) r7_cnt <= 1;
    end
    if (c7_rxv) begin d7_rx <= c7_rx; d7_n <= d7_n + 1; end
  end

  initial begin
    d2_n = 0; d7_n = 0;
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst = 1'b1; tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0; sdi_mode = 0;
    c2_valid = 1'b0; c7_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csn", spi_csn, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_sdo", spi_sdo, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 8'h00);
    chk("rst_rdy", tx_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single-byte loopback frame
    clear_mon();
    send(8'hA5, 1'b1);
    wait_rx(1);
    wait_idle();
    chk("t1_csn_low", csn_low, 68);
    chk("t1_rises", rises, 8);
    chk("t1_rx_n", rx_n, 1);
    chk("t1_rx", rx_log[0], 8'hA5);
    chk("t1_gap", gap_n >= 4, 1);
    chk("t1_sdo_idle", spi_sdo, 0);

    // two-byte frame, csn held across bytes
    clear_mon();
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b1);
    wait_rx(2);
    wait_idle();
    chk("t2_rx0", rx_log[0], 8'h3C);
    chk("t2_rx1", rx_log[1], 8'hC3);
    chk("t2_rises", rises, 16);
    chk("t2_csn_rise", csn_rise, 1);
    chk("t2_csn_low", csn_low, 2*68 + 1);

    // stall in HOLD, then finish the frame
    clear_mon();
    send(8'h12, 1'b0);
    wait_rx(1);
    repeat (200) @(negedge clk);
    chk("t3_state", dut.state, HOLD);
    chk("t3_csn", spi_csn, 0);
    chk("t3_sck", spi_sck, 0);
    chk("t3_rdy", tx_ready, 1);
    chk("t3_rx_n", rx_n, 1);
    send(8'h34, 1'b1);
    wait_rx(2);
    wait_idle();
    chk("t3_rx0", rx_log[0], 8'h12);
    chk("t3_rx1", rx_log[1], 8'h34);
    chk("t3_csn_rise", csn_rise, 1);

    // tied sdi
    sdi_mode = 1;
    clear_mon();
    send(8'h00, 1'b1);
    wait_rx(1);
    wait_idle();
    chk("t4_rx_ff", rx_log[0], 8'hFF);
    chk("t4_sdo_hi", sdo_hi, 0);
    chk("t4_rises", rises, 8);
    sdi_mode = 2;
    clear_mon();
    send(8'hFF, 1'b1);
    wait_rx(1);
    wait_idle();
    chk("t4_rx_00", rx_log[0], 8'h00);
    chk("t4_sdo_hi_ff", sdo_hi, 8);

    // reset during the 4th high phase
    sdi_mode = 0;
    clear_mon();
    send(8'h81, 1'b1);
    k = 0;
    while (!(rises >= 4 && spi_sck) && k < 2000) begin @(negedge clk); k++; end
    chk("t5_reach", rises == 4 && spi_sck, 1);
    rst = 1'b1;
    #1;
    chk("t5_csn", spi_csn, 1);
    chk("t5_sck", spi_sck, 0);
    chk("t5_rxv", rx_valid, 0);
    chk("t5_rdy", tx_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_no_rx", rx_n, 0);
    clear_mon();
    send(8'h5A, 1'b1);
    wait_rx(1);
    wait_idle();
    chk("t5_rx", rx_log[0], 8'h5A);

    // delayed responders at CLK_DIV=2 and 7
    chk("t6_rdy2", c2_ready, 1);
    chk("t6_rdy7", c7_ready, 1);
    c2_valid = 1'b1; c7_valid = 1'b1;
    @(posedge clk);
    #1 c2_valid = 1'b0; c7_valid = 1'b0;
    k = 0;
    while (!(d2_n >= 1 && d7_n >= 1) && k < 1000) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("t6_n2", d2_n, 1);
    chk("t6_n7", d7_n, 1);
    chk("t6_rx2", d2_rx, 8'h96);
    chk("t6_rx7", d7_rx, 8'h96);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
